// File: rtl/kdtree_load_ctrl.sv
// kdtree_load_ctrl: steers the show-ahead input FIFO stream into the node, leaf and
// query memories, assembling each record into one wide write per record.
module kdtree_load_ctrl #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5,
   parameter int LEAF_SIZE  = 8,
   parameter int NUM_LEAVES = 64,
   parameter int NUM_QUERYS = 494,
   localparam int NUM_NODES = NUM_LEAVES - 1,
   localparam int NODE_AW   = (NUM_NODES  > 1) ? $clog2(NUM_NODES)  : 1,
   localparam int LEAF_AW   = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1,
   localparam int SLOT_W    = (LEAF_SIZE  > 1) ? $clog2(LEAF_SIZE)  : 1,
   localparam int QUERY_AW  = (NUM_QUERYS > 1) ? $clog2(NUM_QUERYS) : 1,
   localparam int PW        = PATCH_SIZE * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [DATA_WIDTH-1:0] in_rdata,
   input  logic                  in_rempty_n,
   output logic                  in_deq,
   output logic                  node_wen,
   output logic [NODE_AW-1:0]    node_waddr,
   output logic [2:0]            node_wdim,
   output logic [DATA_WIDTH-1:0] node_wmedian,
   output logic                  leaf_wen,
   output logic [LEAF_AW-1:0]    leaf_waddr,
   output logic [SLOT_W-1:0]     leaf_wslot,
   output logic [PW-1:0]         leaf_wpatch,
   output logic [DATA_WIDTH-1:0] leaf_wpidx,
   output logic                  query_wen,
   output logic [QUERY_AW-1:0]   query_waddr,
   output logic [PW-1:0]         query_wpatch,
   output logic                  busy,
   output logic                  done
);

   localparam int WC_W = $clog2(PATCH_SIZE + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_NODE  = 3'd1;
   localparam logic [2:0] S_LEAF  = 3'd2;
   localparam logic [2:0] S_QUERY = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [WC_W-1:0]     WC_NODE_LAST  = WC_W'(1);
   localparam logic [WC_W-1:0]     WC_LEAF_LAST  = WC_W'(PATCH_SIZE);
   localparam logic [WC_W-1:0]     WC_QUERY_LAST = WC_W'(PATCH_SIZE - 1);
   localparam logic [NODE_AW-1:0]  NODE_LAST     = NODE_AW'(NUM_NODES - 1);
   localparam logic [LEAF_AW-1:0]  LEAF_LAST     = LEAF_AW'(NUM_LEAVES - 1);
   localparam logic [SLOT_W-1:0]   SLOT_LAST     = SLOT_W'(LEAF_SIZE - 1);
   localparam logic [QUERY_AW-1:0] QUERY_LAST    = QUERY_AW'(NUM_QUERYS - 1);

   logic [2:0]          state;
   logic [WC_W-1:0]     wc;
   logic [NODE_AW-1:0]  node_cnt;
   logic [LEAF_AW-1:0]  leaf_cnt;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [QUERY_AW-1:0] query_cnt;
   logic [PW-1:0]       asm_q;
   logic [PW-1:0]       asm_next;

   assign busy   = (state == S_NODE) || (state == S_LEAF) || (state == S_QUERY);
   assign in_deq = busy & in_rempty_n;

   // Head word lands in slot wc; the leaf index word (wc == PATCH_SIZE) matches no slot.
   for (genvar k = 0; k < PATCH_SIZE; k++) begin : g_asm
      assign asm_next[k*DATA_WIDTH +: DATA_WIDTH] =
         (wc == WC_W'(k)) ? in_rdata : asm_q[k*DATA_WIDTH +: DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         wc           <= '0;
         node_cnt     <= '0;
         leaf_cnt     <= '0;
         slot_cnt     <= '0;
         query_cnt    <= '0;
         asm_q        <= '0;
         done         <= 1'b0;
         node_wen     <= 1'b0;
         node_waddr   <= '0;
         node_wdim    <= '0;
         node_wmedian <= '0;
         leaf_wen     <= 1'b0;
         leaf_waddr   <= '0;
         leaf_wslot   <= '0;
         leaf_wpatch  <= '0;
         leaf_wpidx   <= '0;
         query_wen    <= 1'b0;
         query_waddr  <= '0;
         query_wpatch <= '0;
      end else begin
         node_wen  <= 1'b0;
         leaf_wen  <= 1'b0;
         query_wen <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (load_start) begin
                  state     <= S_NODE;
                  done      <= 1'b0;
                  wc        <= '0;
                  node_cnt  <= '0;
                  leaf_cnt  <= '0;
                  slot_cnt  <= '0;
                  query_cnt <= '0;
               end
            end
            S_NODE: begin
               if (in_rempty_n) begin
                  asm_q <= asm_next;
                  if (wc == WC_NODE_LAST) begin
                     wc           <= '0;
                     node_wen     <= 1'b1;
                     node_waddr   <= node_cnt;
                     node_wdim    <= asm_q[2:0];
                     node_wmedian <= in_rdata;
                     if (node_cnt == NODE_LAST) begin
                        node_cnt <= '0;
                        state    <= S_LEAF;
                     end else begin
                        node_cnt <= node_cnt + 1'b1;
                     end
                  end else begin
                     wc <= wc + 1'b1;
                  end
               end
            end
            S_LEAF: begin
               if (in_rempty_n) begin
                  asm_q <= asm_next;
                  if (wc == WC_LEAF_LAST) begin
                     wc          <= '0;
                     leaf_wen    <= 1'b1;
                     leaf_waddr  <= leaf_cnt;
                     leaf_wslot  <= slot_cnt;
                     leaf_wpatch <= asm_q;
                     leaf_wpidx  <= in_rdata;
                     if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (leaf_cnt == LEAF_LAST) begin
                           leaf_cnt <= '0;
                           state    <= S_QUERY;
                        end else begin
                           leaf_cnt <= leaf_cnt + 1'b1;
                        end
                     end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                     end
                  end else begin
                     wc <= wc + 1'b1;
                  end
               end
            end
            S_QUERY: begin
               if (in_rempty_n) begin
                  asm_q <= asm_next;
                  if (wc == WC_QUERY_LAST) begin
                     wc           <= '0;
                     query_wen    <= 1'b1;
                     query_waddr  <= query_cnt;
                     query_wpatch <= asm_next;
                     if (query_cnt == QUERY_LAST) begin
                        query_cnt <= '0;
                        state     <= S_DONE;
                        done      <= 1'b1;
                     end else begin
                        query_cnt <= query_cnt + 1'b1;
                     end
                  end else begin
                     wc <= wc + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/kdtree_load_ctrl.md
Name: kdtree_load_ctrl

Overview:
- Sequences the inbound word stream from the chip input FIFO into the accelerator's three storage targets: internal-node memory, leaf memory and query-patch memory.
- On a load_start pulse it consumes, in a fixed order, NUM_NODES node records (2 words each), NUM_LEAVES*LEAF_SIZE leaf patches (PATCH_SIZE+1 words each) and NUM_QUERYS query patches (PATCH_SIZE words each).
- It assembles each record into one wide memory write and raises done when the stream is complete.
- It sits between the IO-clock input FIFO read side and the memory write ports, ahead of the search FSM.

Parameters:
- DATA_WIDTH, 11, width of one stream word.
- PATCH_SIZE, 5, data words per patch.
- LEAF_SIZE, 8, patches per leaf.
- NUM_LEAVES, 64, leaves in the kd tree; NUM_NODES = NUM_LEAVES-1.
- NUM_QUERYS, 494, query patches (26x19).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle start pulse.
- in_rdata  in  DATA_WIDTH  FIFO head word, valid whenever in_rempty_n=1 (show-ahead).
- in_rempty_n  in  1  FIFO not empty.
- in_deq  out  1  pop FIFO head this cycle.
- node_wen  out  1  internal-node write strobe.
- node_waddr  out  clog2(NUM_NODES)  node number.
- node_wdim  out  3  split dimension, taken from word 0 bits [2:0].
- node_wmedian  out  DATA_WIDTH  median, taken from word 1.
- leaf_wen  out  1  leaf-patch write strobe.
- leaf_waddr  out  clog2(NUM_LEAVES)  leaf number.
- leaf_wslot  out  clog2(LEAF_SIZE)  patch slot within the leaf.
- leaf_wpatch  out  PATCH_SIZE*DATA_WIDTH  patch data; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- leaf_wpidx  out  DATA_WIDTH  original-image patch index (word PATCH_SIZE).
- query_wen  out  1  query write strobe.
- query_waddr  out  clog2(NUM_QUERYS)  query number.
- query_wpatch  out  PATCH_SIZE*DATA_WIDTH  query data, same packing as leaf_wpatch.
- busy  out  1  high in any load state.
- done  out  1  stream fully loaded.

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, in_deq and all wen signals 0; data and address outputs 0.
- States:
  - IDLE: load_start moves to NODE.
  - NODE: after word 1 of node NUM_NODES-1, moves to LEAF.
  - LEAF: after word PATCH_SIZE of slot LEAF_SIZE-1 of leaf NUM_LEAVES-1, moves to QUERY.
  - QUERY: after word PATCH_SIZE-1 of query NUM_QUERYS-1, moves to DONE.
  - DONE: load_start moves to NODE and clears done and all counters.
- in_deq is combinational: (state in NODE/LEAF/QUERY) and in_rempty_n. A word is consumed on each clock edge where in_deq=1. An empty FIFO stalls with no counter or state change.
- Counters: word counter wc counts within a record; record counters count node, slot+leaf and query.
  - Slot wraps LEAF_SIZE-1 to 0 and increments the leaf number.
  - wc wraps at record length: 2 for nodes, PATCH_SIZE+1 for leaves, PATCH_SIZE for queries.
- Assembly: words are captured into a PATCH_SIZE*DATA_WIDTH shift/index register. For nodes, the dim is the low 3 bits of word 0; its upper bits are ignored.
- Write timing: the matching wen is registered high for exactly one cycle, the cycle after the last word of a record is consumed. Address and data are stable for that cycle and hold until the next write.
- Back-to-back records with a non-empty FIFO produce one write every record-length cycles with no bubbles.
- busy = state in {NODE, LEAF, QUERY}.
- done goes high on the same edge that registers the final query_wen, so final query_wen and done are high together. done holds until load_start or rst.
- load_start while busy is ignored.
- Reset mid-load: returns to IDLE immediately; no further writes; partially assembled data is discarded.
- rst and load_start in the same cycle: rst wins.

Test Plan:
- Nominal load: pulse load_start, then feed 126 + 3072 + 2470 words with the FIFO never empty.
  - Required: 63 node_wen, 512 leaf_wen and 494 query_wen pulses.
  - Required: done high exactly at the final query_wen; total 5668 consuming cycles.
- Node packing: node words (13, 777), i.e. dim word 13 = 0b1101.
  - Required: node_wen with node_waddr=0, node_wdim=5, node_wmedian=777.
- Leaf packing and wrap: leaf-phase words 1,2,3,4,5,42 for the 9th patch.
  - Required: leaf_waddr=1, leaf_wslot=0, leaf_wpatch word k = k+1, leaf_wpidx=42.
- Stall: toggle in_rempty_n off for 3 cycles mid-query.
  - Required: in_deq low during the gap, no counter change, query_waddr sequence unbroken.
- Ignored start and restart: load_start during LEAF has no effect. load_start in DONE restarts at node_waddr=0 with done cleared next cycle.
- Reset mid-operation: assert rst during QUERY word 2.
  - Required: next cycle busy=0, done=0, all wen=0.
  - A new load restarts from node 0.
